// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low a..g patterns ({a,b,c,d,e,f,g}, a = bit 6)
// and the pattern-to-nibble decode used by both the scan driver and the capture side.
package seg7_pkg;

  localparam int SEG_W  = 7;
  localparam int DIGITS = 8;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h01;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h4C;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h20;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h0F;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h04;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h60;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h31;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h42;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h38;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic       hit;
    logic       blank;
    logic [3:0] nib;
  } seg_dec_t;

  function automatic seg_dec_t seg7_decode_fn(input logic [SEG_W-1:0] pat);
    seg_dec_t d;
    d     = '0;
    d.hit = 1'b1;
    case (pat)
      SEG_0:     d.nib = 4'h0;
      SEG_1:     d.nib = 4'h1;
      SEG_2:     d.nib = 4'h2;
      SEG_3:     d.nib = 4'h3;
      SEG_4:     d.nib = 4'h4;
      SEG_5:     d.nib = 4'h5;
      SEG_6:     d.nib = 4'h6;
      SEG_7:     d.nib = 4'h7;
      SEG_8:     d.nib = 4'h8;
      SEG_9:     d.nib = 4'h9;
      SEG_A:     d.nib = 4'hA;
      SEG_B:     d.nib = 4'hB;
      SEG_C:     d.nib = 4'hC;
      SEG_D:     d.nib = 4'hD;
      SEG_E:     d.nib = 4'hE;
      SEG_F:     d.nib = 4'hF;
      SEG_BLANK: begin
        d.hit   = 1'b0;
        d.blank = 1'b1;
      end
      default:   d.hit = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational decode of one active-low segment pattern to a hex nibble.
// Zero latency; hit = table match, blank = all segments off, neither = undecodable.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pat,
  output logic [3:0]       nib,
  output logic             hit,
  output logic             blank
);

  seg_dec_t dec;

  always_comb begin
    dec   = seg7_decode_fn(pat);
    nib   = dec.nib;
    hit   = dec.hit;
    blank = dec.blank;
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Passive capture of a multiplexed 7-segment scan: glitch filter, decode, 8-digit hold.
// Latch at the STABLE_CYCLES-th stable edge, outputs/pulses visible after it; no back-pressure.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [SEG_W-1:0]    out7,
  input  logic [DIGITS-1:0]   en_out,
  input  logic                clear,
  output logic [4*DIGITS-1:0] digits,
  output logic [DIGITS-1:0]   digit_valid,
  output logic                frame_done,
  output logic                bad_pattern,
  output logic [7:0]          bad_count
);

  localparam logic [3:0] RUN_MAX  = 4'(STABLE_CYCLES);
  localparam logic [3:0] RUN_FIRE = 4'(STABLE_CYCLES - 1);

  logic [SEG_W-1:0]  samp_seg;
  logic [DIGITS-1:0] samp_en;
  logic [3:0]        run_cnt;
  logic [3:0]        run_nxt;
  logic [DIGITS-1:0] seen;
  logic [DIGITS-1:0] seen_nxt;
  logic              sel_vld;
  logic [2:0]        sel_idx;
  logic              same;
  logic              latch;
  logic              frame_hit;
  logic [3:0]        dec_nib;
  logic              dec_hit;
  logic              dec_blank;

  seg7_decode u_decode (
    .pat   (out7),
    .nib   (dec_nib),
    .hit   (dec_hit),
    .blank (dec_blank)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!en_out[i]) sel_idx = 3'(i);
    end
    sel_vld = ($countones(~en_out) == 1);
    same    = (out7 == samp_seg) && (en_out == samp_en);

    // Run saturates at RUN_MAX so a long dwell can never re-fire.
    if (!sel_vld)               run_nxt = '0;
    else if (!same)             run_nxt = 4'd1;
    else if (run_cnt == RUN_MAX) run_nxt = run_cnt;
    else                        run_nxt = run_cnt + 4'd1;

    latch = sel_vld && same && (run_cnt == RUN_FIRE);

    seen_nxt = seen;
    if (latch && (dec_hit || dec_blank)) seen_nxt[sel_idx] = 1'b1;
    frame_hit = latch && (seen_nxt == '1);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      samp_seg    <= SEG_BLANK;
      samp_en     <= '1;
      run_cnt     <= '0;
      seen        <= '0;
      digits      <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      bad_pattern <= 1'b0;
      bad_count   <= '0;
    end else begin
      samp_seg    <= out7;
      samp_en     <= en_out;
      frame_done  <= 1'b0;
      bad_pattern <= 1'b0;
      if (clear) begin
        run_cnt     <= '0;
        seen        <= '0;
        digits      <= '0;
        digit_valid <= '0;
        bad_count   <= '0;
      end else begin
        run_cnt <= run_nxt;
        if (latch) begin
          if (dec_hit) begin
            digits[{sel_idx, 2'b00} +: 4] <= dec_nib;
            digit_valid[sel_idx]          <= 1'b1;
          end else if (dec_blank) begin
            digit_valid[sel_idx] <= 1'b0;
          end else begin
            bad_pattern <= 1'b1;
            if (bad_count != 8'hFF) bad_count <= bad_count + 8'd1;
          end
          seen       <= frame_hit ? '0 : seen_nxt;
          frame_done <= frame_hit;
        end
      end
    end
  end

endmodule

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Receive-side counterpart of the top-level multiplexed seven-segment driver. It watches the `out7` / `en_out` pair that the processor top drives toward the board display. For each scanned digit it filters out glitches, decodes the segment pattern back to a hex nibble, and holds the eight reconstructed digits with valid flags and a frame-complete pulse. It sits beside the processor top in benches and on-board debug so that displayed values can be checked numerically instead of by eye.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4. Number of consecutive rising edges that must sample an identical valid input before a digit is latched. Legal range 2..15.

Ports:
- `Clk`, input, 1. Single clock. All logic is on the rising edge.
- `Reset_n`, input, 1. Synchronous, active-low reset.
- `out7`, input, 7. Segment bus, `{a,b,c,d,e,f,g}` (`out7[6]` = a). Active-low.
- `en_out`, input, 8. Digit enables. Active-low, one-cold. Bit i selects digit i.
- `clear`, input, 1. Synchronous clear of captured state.
- `digits`, output, 32. Captured nibbles. Digit i occupies `[4i+3:4i]`.
- `digit_valid`, output, 8. Bit i is 1 when digit i holds a decoded hex value.
- `frame_done`, output, 1. One-cycle pulse when all 8 digits have been latched since the last pulse or clear.
- `bad_pattern`, output, 1. One-cycle pulse when a stable pattern is undecodable.
- `bad_count`, output, 8. Saturating count of `bad_pattern` events.

## Operation
- **Valid select:** `en_out` has exactly one 0 bit. Any other value (all 1s, or multiple 0s) is idle: the stability run resets and nothing is latched.
- **Stability filter:**
  - Inputs `{out7, en_out}` are registered every edge.
  - A run counts consecutive edges at which the sampled value equals the previous sample and the select is valid. Any change restarts the run at 1.
  - A latch event fires once, at the `STABLE_CYCLES`-th edge of a run. A longer dwell never re-fires.
- **Decode table** (active-low a..g, hex):
  - 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F
  - 8=00, 9=04, A=08, b=60, C=31, d=42, E=30, F=38
  - Blank = 7F
- **On a latch event for digit i:**
  - Table hit: `digits[i]` ← nibble, `digit_valid[i]` ← 1, seen-mask bit i ← 1.
  - Blank: `digit_valid[i]` ← 0, `digits[i]` unchanged, seen-mask bit i ← 1.
  - Any other pattern: `bad_pattern` pulses, `bad_count` increments (saturating at FF), `digits` and `digit_valid` unchanged, seen-mask unchanged.
- **Frame:** when the seen-mask becomes FF (including via the current latch), `frame_done` pulses for one cycle and the mask returns to 00 on that same edge.
- **`clear`:** zeroes `digits`, `digit_valid`, seen-mask, run counter and `bad_count`. It suppresses any latch event on the same edge, so clear wins.

## Timing
- **Reset values:** `digits`=0, `digit_valid`=00, `frame_done`=0, `bad_pattern`=0, `bad_count`=00. Internal sample register is `{7F, FF}`, run counter 0, seen-mask 00.
- **Reset mid-run:** discards the run. After `Reset_n` rises, a full `STABLE_CYCLES` run is required again.
- **Latency:** input constant from edge k is counted as run edge 1 at k. The latch fires at edge k+`STABLE_CYCLES`-1, and outputs are visible after that edge.
- **Pulse alignment:** `frame_done` and `bad_pattern` are registered and asserted in the cycle following the latching edge, for exactly one cycle.
- **Dwell limit:** a dwell shorter than `STABLE_CYCLES` edges is ignored entirely.
- **No duplicate counts:** a digit re-scanned with the same pattern after an intervening change latches again. The seen-mask bit stays 1, so no double count occurs.
- **Throughput:** one latch per `STABLE_CYCLES` edges at most. There is no back-pressure; the block is a passive observer.

## Structure
- Package `seg7_pkg` holds:
  - the 16 active-low pattern constants and `SEG_BLANK` = 7'h7F
  - `SEG_W` = 7, `DIGITS` = 8
  - the shared decode function, also usable by the driver side
- Sub-module `seg7_decode` (combinational): 7-bit pattern → 4-bit nibble, hit, blank.
- The top holds the sample register, run counter, latch logic, seen-mask and counters.

## Test plan
- **Single digit:** after reset, hold `en_out`=FE, `out7`=12 for 4 edges → `digits[3:0]`=2, `digit_valid`=01. No `frame_done`.
- **Glitch rejection:** `en_out`=FD, `out7`=06 for 3 edges, then `en_out`=FF → `digits`/`digit_valid` unchanged.
- **Full frame:** scan digits 0..7 with patterns for 0..7, 6 edges each → `digits`=32'h76543210, `digit_valid`=FF, exactly one `frame_done` pulse.
- **Bad and blank patterns:**
  - digit 3 with `out7`=7E for 4 edges → one `bad_pattern` pulse, `bad_count`=1, digit 3 unchanged
  - then `out7`=7F → `digit_valid[3]`=0
- **Clear and reset:**
  - assert `clear` on the edge a latch would fire → nothing latched, all outputs at reset values
  - drop `Reset_n` mid-run → next latch needs 4 fresh edges
